// File: rtl/step_pulse_gen_pkg.sv
// Shared types and default timing for the button step/pulse generator.
// Timing constants are cycles of the 100 MHz board clock.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_FIRE   = 2'd1,
    CH_HOLD   = 2'd2,
    CH_REPEAT = 2'd3
  } ch_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } st_state_t;

  localparam int unsigned DEF_N_BTN         = 5;
  localparam int unsigned DEF_STEP_IDX      = 4;
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;
  localparam int unsigned DEF_STRETCH       = 1_000_000;
  localparam int unsigned DEF_CNT_W         = 27;

endpackage

// File: rtl/step_pulse_gen_channel.sv
// One button channel: level-to-pulse FSM with auto-repeat counter.
// The counter also runs in the pulse cycle so repeat spacing is exact.
module step_pulse_channel
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic rep_en,
  output logic pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LD_DELAY  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] LD_PERIOD = CNT_W'(REPEAT_PERIOD - 1);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_dec;

  assign cnt_dec = (cnt == '0) ? '0 : cnt - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CH_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state)
        CH_IDLE: begin
          if (btn) begin
            state <= CH_FIRE;
            cnt   <= LD_DELAY;
            pulse <= 1'b1;
            held  <= 1'b1;
          end else begin
            held  <= 1'b0;
          end
        end
        CH_FIRE, CH_REPEAT: begin
          if (!btn) begin
            state <= CH_IDLE;
            held  <= 1'b0;
          end else begin
            state <= CH_HOLD;
            cnt   <= cnt_dec;
          end
        end
        CH_HOLD: begin
          if (!btn) begin
            state <= CH_IDLE;
            held  <= 1'b0;
          end else if (!rep_en) begin
            state <= CH_HOLD;
          end else if (cnt == '0) begin
            state <= CH_REPEAT;
            cnt   <= LD_PERIOD;
            pulse <= 1'b1;
          end else begin
            cnt   <= cnt_dec;
          end
        end
        default: begin
          state <= CH_IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Button pulse generator with auto-repeat, plus a stretched,
// glitch-free single-step clock and its step counter.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned N_BTN         = DEF_N_BTN,
  parameter int unsigned STEP_IDX      = DEF_STEP_IDX,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned STRETCH       = DEF_STRETCH,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] pulse_out,
  output logic [N_BTN-1:0] held_out,
  output logic             step_clk,
  output logic [15:0]      step_count
);

  localparam logic [CNT_W-1:0] LD_STRETCH = CNT_W'(STRETCH - 1);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    step_pulse_channel #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn_in[g]),
      .rep_en (repeat_en[g]),
      .pulse  (pulse_out[g]),
      .held   (held_out[g])
    );
  end

  st_state_t        s_state;
  logic [CNT_W-1:0] s_cnt;

  // step_clk is a flop so it cannot glitch; pulses while busy are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      s_state    <= S_IDLE;
      s_cnt      <= '0;
      step_clk   <= 1'b0;
      step_count <= '0;
    end else begin
      unique case (s_state)
        S_IDLE: begin
          if (pulse_out[STEP_IDX]) begin
            s_state    <= S_HIGH;
            s_cnt      <= LD_STRETCH;
            step_clk   <= 1'b1;
            step_count <= step_count + 16'd1;
          end
        end
        S_HIGH: begin
          if (s_cnt == '0) begin
            s_state  <= S_LOW;
            s_cnt    <= LD_STRETCH;
            step_clk <= 1'b0;
          end else begin
            s_cnt    <= s_cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (s_cnt == '0) begin
            s_state <= S_IDLE;
          end else begin
            s_cnt   <= s_cnt - 1'b1;
          end
        end
        default: begin
          s_state  <= S_IDLE;
          step_clk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed plan steps plus random presses,
// checked every cycle against an arithmetic reference model.
module tb_step_pulse_gen;

  localparam int D = 8;
  localparam int P = 4;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn_in;
  logic [4:0]  repeat_en;
  logic [4:0]  pulse_out;
  logic [4:0]  held_out;
  logic        step_clk;
  logic [15:0] step_count;

  int n_err = 0;
  int n_chk = 0;

  step_pulse_gen #(
    .N_BTN         (5),
    .STEP_IDX      (4),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P),
    .STRETCH       (S),
    .CNT_W         (27)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .pulse_out  (pulse_out),
    .held_out   (held_out),
    .step_clk   (step_clk),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  // reference model: counted cycles since last pulse per channel,
  // step_clk from the time of its last accepted rise
  logic [4:0]  m_pulse;
  logic [4:0]  m_held;
  int          acc [5];
  int          intv [5];
  int          cyc;
  bit          have_rise;
  int          last_rise;
  logic [15:0] m_cnt;

  function automatic logic m_clk();
    return have_rise && cyc >= last_rise && cyc < last_rise + S;
  endfunction

  task automatic model_edge(input logic [4:0] b, input logic [4:0] e,
                            input logic r);
    logic old_p4;
    old_p4 = m_pulse[4];
    for (int i = 0; i < 5; i++) begin
      if (r) begin
        m_pulse[i] = 1'b0;
        m_held[i]  = 1'b0;
        acc[i]     = 0;
      end else if (!m_held[i]) begin
        m_pulse[i] = b[i];
        m_held[i]  = b[i];
        acc[i]     = 0;
        intv[i]    = D;
      end else if (!b[i]) begin
        m_pulse[i] = 1'b0;
        m_held[i]  = 1'b0;
      end else begin
        if (m_pulse[i] || e[i]) acc[i]++;
        if (acc[i] == intv[i]) begin
          m_pulse[i] = 1'b1;
          acc[i]     = 0;
          intv[i]    = P;
        end else begin
          m_pulse[i] = 1'b0;
        end
      end
    end
    if (r) begin
      have_rise = 1'b0;
      m_cnt     = 16'd0;
    end else if (old_p4 && (!have_rise || cyc >= last_rise + 2 * S)) begin
      have_rise = 1'b1;
      last_rise = cyc + 1;
      m_cnt     = m_cnt + 16'd1;
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
             tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic [4:0] b, input logic [4:0] e,
                      input logic r);
    btn_in    = b;
    repeat_en = e;
    reset     = r;
    @(posedge clk);
    model_edge(b, e, r);
    #1;
    chk("pulse_out", 32'(pulse_out), 32'(m_pulse));
    chk("held_out", 32'(held_out), 32'(m_held));
    chk("step_clk", 32'(step_clk), 32'(m_clk()));
    chk("step_count", 32'(step_count), 32'(m_cnt));
  endtask

  int          q[$];
  int          exp3 [6] = '{0, 8, 12, 16, 20, 24};
  int          n0;
  int          nhigh;
  logic [4:0]  rb;
  logic [4:0]  re;

  initial begin
    m_pulse   = '0;
    m_held    = '0;
    cyc       = 0;
    have_rise = 1'b0;
    last_rise = 0;
    m_cnt     = '0;
    for (int i = 0; i < 5; i++) begin
      acc[i]  = 0;
      intv[i] = D;
    end

    // reset with all buttons held
    tick(5'h1F, 5'h00, 1'b1);
    tick(5'h1F, 5'h00, 1'b1);
    chk("rst_pulse", 32'(pulse_out), 32'h0);
    chk("rst_held", 32'(held_out), 32'h0);
    chk("rst_count", 32'(step_count), 32'h0);
    tick(5'h1F, 5'h00, 1'b0);
    chk("rst_rel_pulse", 32'(pulse_out), 32'h1F);
    tick(5'h1F, 5'h00, 1'b0);
    chk("rst_rel_once", 32'(pulse_out), 32'h0);
    chk("rst_rel_held", 32'(held_out), 32'h1F);
    repeat (10) tick(5'h00, 5'h00, 1'b0);
    chk("rst_step", 32'(step_count), 32'd1);

    // single press, no repeat
    n0 = 0;
    for (int j = 1; j <= 3; j++) begin
      tick(5'h01, 5'h00, 1'b0);
      if (pulse_out[0]) n0++;
      if (j == 1) chk("single_lat", 32'(pulse_out[0]), 32'h1);
    end
    chk("single_held", 32'(held_out[0]), 32'h1);
    tick(5'h00, 5'h00, 1'b0);
    chk("single_rel", 32'(held_out[0]), 32'h0);
    repeat (12) begin
      tick(5'h00, 5'h00, 1'b0);
      if (pulse_out[0]) n0++;
    end
    chk("single_cnt", 32'(n0), 32'd1);

    // auto-repeat on channel 1, release on the expiry edge
    for (int j = 1; j <= 32; j++) begin
      tick((j <= 28) ? 5'h02 : 5'h00, 5'h02, 1'b0);
      if (pulse_out[1]) q.push_back(j - 1);
    end
    chk("rep_num", 32'(q.size()), 32'd6);
    for (int k = 0; k < 6 && k < q.size(); k++)
      chk("rep_off", 32'(q[k]), 32'(exp3[k]));

    // stretch: second pulse during S_HIGH is dropped
    nhigh = 0;
    tick(5'h10, 5'h00, 1'b0);
    tick(5'h00, 5'h00, 1'b0);
    if (step_clk) nhigh++;
    tick(5'h10, 5'h00, 1'b0);
    if (step_clk) nhigh++;
    for (int j = 0; j < 12; j++) begin
      tick(5'h00, 5'h00, 1'b0);
      if (step_clk) nhigh++;
    end
    chk("stretch_high", 32'(nhigh), 32'd3);
    chk("stretch_drop", 32'(step_count), 32'd2);

    // wrap from FFFF, then reset in the middle of S_HIGH
    force dut.step_count = 16'hFFFF;
    #1;
    release dut.step_count;
    m_cnt = 16'hFFFF;
    tick(5'h10, 5'h00, 1'b0);
    tick(5'h00, 5'h00, 1'b0);
    chk("wrap_count", 32'(step_count), 32'h0);
    chk("wrap_clk", 32'(step_clk), 32'h1);
    repeat (8) tick(5'h00, 5'h00, 1'b0);
    tick(5'h10, 5'h00, 1'b0);
    tick(5'h00, 5'h00, 1'b0);
    tick(5'h00, 5'h00, 1'b0);
    chk("mid_clk_pre", 32'(step_clk), 32'h1);
    tick(5'h00, 5'h00, 1'b1);
    chk("mid_rst_clk", 32'(step_clk), 32'h0);
    chk("mid_rst_cnt", 32'(step_count), 32'h0);
    tick(5'h00, 5'h00, 1'b0);

    // simultaneous press of every button
    tick(5'h1F, 5'h00, 1'b0);
    chk("simul_pulse", 32'(pulse_out), 32'h1F);
    chk("simul_clk0", 32'(step_clk), 32'h0);
    tick(5'h1F, 5'h00, 1'b0);
    chk("simul_clk1", 32'(step_clk), 32'h1);
    chk("simul_cnt", 32'(step_count), 32'h1);
    repeat (8) tick(5'h00, 5'h00, 1'b0);

    // random presses, repeat enables and occasional reset
    rb = '0;
    re = '0;
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(7) == 0) rb[i] = ~rb[i];
      if ($urandom_range(15) == 0) re = 5'($urandom);
      tick(rb, re, ($urandom_range(149) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
